// File: rtl/instr_mem_stream.sv
// instr_mem_stream
//   Writable instruction memory with a registered, valid/ready-handshaked
//   read port for the fetch stage.
//
//   Ports:
//     clk        clock, rising-edge active
//     rst        asynchronous active-low reset (clears response register only)
//     load_en    write load_data into the array at load_idx this cycle
//     load_idx   word index to write (indices >= DEPTH are dropped)
//     load_data  word to write
//     req_valid  fetch request present
//     req_addr   byte address (PC) of the fetch
//     req_ready  request will be accepted this cycle
//     flush      discard held / in-flight response, block acceptance
//     rsp_valid  response present
//     rsp_ready  consumer takes the response this cycle
//     rsp_instr  fetched word, or NOP_WORD on fault
//     rsp_pc     req_addr of the request that produced the response
//     rsp_fault  {out_of_range, misaligned}
module instr_mem_stream #(
  parameter int                 DATA_W   = 32,
  parameter int                 DEPTH    = 64,
  parameter int                 IDX_W    = $clog2(DEPTH),
  parameter logic [DATA_W-1:0]  NOP_WORD = 32'hE1A00000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [IDX_W-1:0]  load_idx,
  input  logic [DATA_W-1:0] load_data,
  input  logic              req_valid,
  input  logic [31:0]       req_addr,
  output logic              req_ready,
  input  logic              flush,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_instr,
  output logic [31:0]       rsp_pc,
  output logic [1:0]        rsp_fault
);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic              misalign;
  logic              out_range;
  logic [IDX_W-1:0]  rd_idx;
  logic [DATA_W-1:0] rd_word;

  // Array is intentionally not reset; it survives rst.
  always_ff @(posedge clk) begin
    if (load_en && (32'(load_idx) < 32'(DEPTH))) begin
      mem[load_idx] <= load_data;
    end
  end

  // Loads and flushes block fetches, so a read never sees a same-cycle write.
  assign req_ready = rst & ~load_en & ~flush & (~rsp_valid | rsp_ready);
  assign accept    = req_valid & req_ready;

  // Full 30-bit word-index compare: high address bits never alias into range.
  assign misalign  = (req_addr[1:0] != 2'b00);
  assign out_range = ({2'b00, req_addr[31:2]} >= 32'(DEPTH));
  assign rd_idx    = req_addr[IDX_W+1:2];

  always_comb begin
    rd_word = NOP_WORD;
    if (!misalign && !out_range) begin
      rd_word = mem[rd_idx];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid <= 1'b0;
      rsp_instr <= '0;
      rsp_pc    <= '0;
      rsp_fault <= '0;
    end else if (flush) begin
      rsp_valid <= 1'b0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_instr <= rd_word;
      rsp_pc    <= req_addr;
      rsp_fault <= {out_range, misalign};
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_mem_stream.sv
// tb_instr_mem_stream
//   Directed bench for instr_mem_stream (DEPTH=64). A reference model
//   derived from the memory's rules is checked against the DUT on every
//   falling edge; literal expectations at key points pin the model.
module tb_instr_mem_stream;

  localparam int DEPTH = 64;
  localparam logic [31:0] NOP = 32'hE1A00000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load_en = 1'b0;
  logic [5:0]  load_idx = '0;
  logic [31:0] load_data = '0;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic        req_ready;
  logic        flush = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_instr;
  logic [31:0] rsp_pc;
  logic [1:0]  rsp_fault;

  int checks = 0;
  int errors = 0;

  instr_mem_stream #(.DATA_W(32), .DEPTH(DEPTH), .NOP_WORD(NOP)) dut (
    .clk       (clk),
    .rst       (rst),
    .load_en   (load_en),
    .load_idx  (load_idx),
    .load_data (load_data),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .flush     (flush),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_instr (rsp_instr),
    .rsp_pc    (rsp_pc),
    .rsp_fault (rsp_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_mem [DEPTH];
  logic        e_valid = 1'b0;
  logic [31:0] e_instr = '0;
  logic [31:0] e_pc    = '0;
  logic [1:0]  e_fault = '0;

  function automatic logic [1:0] fault_of(input logic [31:0] a);
    logic [1:0] f;
    f[0] = (a % 4) != 0;
    f[1] = (a / 4) >= DEPTH;
    return f;
  endfunction

  function automatic logic exp_ready();
    return rst && !load_en && !flush && (!e_valid || rsp_ready);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      e_valid = 1'b0;
      e_instr = '0;
      e_pc    = '0;
      e_fault = '0;
    end else begin
      logic rdy;
      rdy = exp_ready();
      if (flush) begin
        e_valid = 1'b0;
      end else if (req_valid && rdy) begin
        e_valid = 1'b1;
        e_pc    = req_addr;
        e_fault = fault_of(req_addr);
        e_instr = (e_fault != 2'b00) ? NOP : m_mem[req_addr / 4];
      end else if (e_valid && rsp_ready) begin
        e_valid = 1'b0;
      end
      if (load_en && (int'(load_idx) < DEPTH)) m_mem[load_idx] = load_data;
    end
  end

  always @(negedge clk) begin
    chk("cmp_rsp_valid", 64'(rsp_valid), 64'(e_valid));
    chk("cmp_rsp_instr", 64'(rsp_instr), 64'(e_instr));
    chk("cmp_rsp_pc",    64'(rsp_pc),    64'(e_pc));
    chk("cmp_rsp_fault", 64'(rsp_fault), 64'(e_fault));
    chk("cmp_req_ready", 64'(req_ready), 64'(exp_ready()));
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string nm, input logic v, input logic [31:0] ins,
                     input logic [31:0] pc, input logic [1:0] f);
    chk({nm, "_valid"}, 64'(rsp_valid), 64'(v));
    chk({nm, "_instr"}, 64'(rsp_instr), 64'(ins));
    chk({nm, "_pc"},    64'(rsp_pc),    64'(pc));
    chk({nm, "_fault"}, 64'(rsp_fault), 64'(f));
  endtask

  logic [31:0] prog [4];

  initial begin
    prog[0] = 32'hE3A00014;
    prog[1] = 32'hE3A01A01;
    prog[2] = 32'hE3A02103;
    prog[3] = 32'hE0923002;

    // Reset state
    cyc(); cyc();
    lit("reset", 1'b0, 32'h0, 32'h0, 2'b00);
    chk("reset_req_ready", 64'(req_ready), 64'd0);
    rst = 1'b1;

    // Load program plus the last word of the array
    for (int unsigned i = 0; i < 4; i++) begin
      load_en = 1'b1; load_idx = 6'(i); load_data = prog[i];
      #1 chk("load_req_ready", 64'(req_ready), 64'd0);
      cyc();
    end
    load_en = 1'b1; load_idx = 6'd63; load_data = 32'hCAFEF00D;
    cyc();
    load_en = 1'b0;

    // Stream: four back-to-back fetches
    rsp_ready = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_addr = 32'(i * 4);
      cyc();
      lit("stream", 1'b1, prog[i], 32'(i * 4), 2'b00);
    end
    req_valid = 1'b0;
    cyc();
    chk("stream_drain", 64'(rsp_valid), 64'd0);

    // Backpressure
    req_valid = 1'b1; req_addr = 32'd4; rsp_ready = 1'b0;
    cyc();
    req_addr = 32'd8;
    for (int unsigned i = 0; i < 3; i++) begin
      cyc();
      lit("hold", 1'b1, 32'hE3A01A01, 32'd4, 2'b00);
      chk("hold_req_ready", 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    #1 chk("release_req_ready", 64'(req_ready), 64'd1);
    cyc();
    lit("after_hold", 1'b1, 32'hE3A02103, 32'd8, 2'b00);
    req_valid = 1'b0;
    cyc();

    // Faults and range boundaries
    req_valid = 1'b1;
    req_addr = 32'h6;        cyc(); lit("misalign", 1'b1, NOP, 32'h6, 2'b01);
    req_addr = 32'h100;      cyc(); lit("range",    1'b1, NOP, 32'h100, 2'b10);
    req_addr = 32'h102;      cyc(); lit("both",     1'b1, NOP, 32'h102, 2'b11);
    req_addr = 32'hFC;       cyc(); lit("last",     1'b1, 32'hCAFEF00D, 32'hFC, 2'b00);
    req_addr = 32'h80000000; cyc(); lit("high",     1'b1, NOP, 32'h80000000, 2'b10);
    req_valid = 1'b0;
    cyc();

    // Flush with a pending response and an offered request
    req_valid = 1'b1; req_addr = 32'h0; rsp_ready = 1'b0;
    cyc();
    req_addr = 32'hC; flush = 1'b1;
    #1 chk("flush_req_ready", 64'(req_ready), 64'd0);
    cyc();
    lit("flush", 1'b0, 32'hE3A00014, 32'h0, 2'b00);
    flush = 1'b0;
    cyc();
    lit("post_flush", 1'b1, 32'hE0923002, 32'hC, 2'b00);
    req_valid = 1'b0; rsp_ready = 1'b1;
    cyc();

    // Load blocks a concurrent fetch; new word is then visible
    load_en = 1'b1; load_idx = 6'd2; load_data = 32'h12345678;
    req_valid = 1'b1; req_addr = 32'h8;
    #1 chk("ldblk_req_ready", 64'(req_ready), 64'd0);
    cyc();
    chk("ldblk_valid", 64'(rsp_valid), 64'd0);
    load_en = 1'b0;
    cyc();
    lit("ldblk_fetch", 1'b1, 32'h12345678, 32'h8, 2'b00);
    req_valid = 1'b0;
    cyc();

    // Asynchronous reset mid-cycle
    req_valid = 1'b1; req_addr = 32'h4; rsp_ready = 1'b0;
    cyc();
    req_valid = 1'b0;
    chk("pre_areset_valid", 64'(rsp_valid), 64'd1);
    #2 rst = 1'b0;
    #1 lit("areset", 1'b0, 32'h0, 32'h0, 2'b00);
    chk("areset_req_ready", 64'(req_ready), 64'd0);
    cyc();
    rst = 1'b1;
    req_valid = 1'b1; req_addr = 32'h0; rsp_ready = 1'b1;
    cyc();
    lit("post_reset", 1'b1, 32'hE3A00014, 32'h0, 2'b00);
    req_valid = 1'b0;
    cyc(); cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
